// File: rtl/instmem_loader.sv
// instmem_loader: receives a framed program image over a byte stream
// (SYNC, LEN, LEN data bytes, CHECK) and writes the data bytes into
// instruction memory locations 0..LEN-1. The core is held in reset
// (cpu_hold) until a complete image with a matching 8-bit additive
// checksum has been written.
module instmem_loader #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    N_LOCATIONS = 64,
    parameter logic [WORD_WIDTH-1:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t                state;
    logic [CW-1:0]         len;
    logic [WORD_WIDTH-1:0] acc;
    logic                  xfer;
    logic                  len_ok;
    logic                  last_data;

    // A byte moves only when both sides agree at the clock edge.
    assign xfer      = in_valid && in_ready;
    // Legal frame lengths are 1..N_LOCATIONS; compared in int so a large
    // N_LOCATIONS never truncates against the byte width.
    assign len_ok    = (in_data != '0) && (int'(in_data) <= N_LOCATIONS);
    // The byte being accepted in DATA is the final one of the frame.
    assign last_data = ((load_count + CW'(1)) == len);

    // Frame parser, write-port driver and status flags, all registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            load_count <= '0;
            acc        <= '0;
            len        <= '0;
        end else begin
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            if (xfer) begin
                case (state)
                    // Waiting for a frame start; a finished or rejected
                    // frame can be replaced by a new one at any time.
                    IDLE, DONE, ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            state      <= LEN;
                            load_done  <= 1'b0;
                            load_err   <= 1'b0;
                            load_count <= '0;
                            acc        <= '0;
                            cpu_hold   <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (len_ok) begin
                            len   <= CW'(in_data);
                            state <= DATA;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    // One memory write per data byte; the address is the
                    // running count, which cannot pass N_LOCATIONS-1.
                    DATA: begin
                        mem_we     <= 1'b1;
                        mem_waddr  <= load_count[ADDR_WIDTH-1:0];
                        mem_wdata  <= in_data;
                        load_count <= load_count + CW'(1);
                        acc        <= acc + in_data;
                        if (last_data) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (in_data == acc) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instmem_loader.sv
// tb_instmem_loader: drives byte streams into instmem_loader and checks the
// observed memory writes and status against a frame-level reference parser.
module tb_instmem_loader;

    localparam int NL = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [5:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [6:0] load_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int excl_viol = 0;

    logic [7:0] stim_q[$];
    logic [7:0] sent_q[$];
    int         acc_q[$];
    int         wa_q[$], wd_q[$], wc_q[$];
    int         ea_q[$], ed_q[$], ec_q[$];
    logic       e_done, e_err, e_hold;
    int         e_count;

    instmem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write with the cycle it became visible.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(int'(mem_waddr));
            wd_q.push_back(int'(mem_wdata));
            wc_q.push_back(cyc);
        end
        if (load_done && load_err) excl_viol++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        sent_q.delete(); acc_q.delete();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        stim_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    // Send one byte after 'gap' idle cycles; returns at the negedge after
    // the accepting clock edge, recording which edge accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = b;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got in_ready=%0b required 1", in_ready);
        end
        sent_q.push_back(b);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each byte.
    task automatic send_stim(input int gap);
        foreach (stim_q[i])
            send_byte(stim_q[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    endtask

    // Frame-level parser of everything accepted since reset: skip to a sync
    // byte, read the length, take that many data bytes (each written at the
    // edge after it was accepted) and compare the mod-256 sum with the
    // checksum byte. An unfinished frame leaves the flags cleared.
    task automatic run_model();
        int i, n, L, sum, k;
        logic stop;
        ea_q.delete(); ed_q.delete(); ec_q.delete();
        e_done = 0; e_err = 0; e_hold = 1; e_count = 0;
        i = 0; n = sent_q.size(); stop = 0;
        while (i < n && !stop) begin
            if (sent_q[i] != 8'hA5) begin
                i++;
            end else begin
                e_done = 0; e_err = 0; e_hold = 1; e_count = 0;
                i++;
                if (i >= n) stop = 1;
                else begin
                    L = int'(sent_q[i]); i++;
                    if (L == 0 || L > NL) e_err = 1;
                    else begin
                        sum = 0;
                        for (k = 0; k < L && i < n; k++) begin
                            ea_q.push_back(e_count);
                            ed_q.push_back(int'(sent_q[i]));
                            ec_q.push_back(acc_q[i]);
                            e_count++;
                            sum = (sum + int'(sent_q[i])) % 256;
                            i++;
                        end
                        if (k < L || i >= n) stop = 1;
                        else begin
                            if (int'(sent_q[i]) == sum) begin e_done = 1; e_hold = 0; end
                            else e_err = 1;
                            i++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_waddr, mem_wdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_port: got rdy=%0b we=%0b a=%0d d=%0h required 0 0 0 0",
                     in_ready, mem_we, mem_waddr, mem_wdata);
        end
        checks++;
        if ({cpu_hold, load_done, load_err, load_count} !== {3'b100, 7'd0}) begin
            errors++;
            $display("FAIL reset_status: got hold=%0b done=%0b err=%0b cnt=%0d required 1 0 0 0",
                     cpu_hold, load_done, load_err, load_count);
        end
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic test_good_frame();
        do_reset();
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_stim(0);
        run_model();
        checks++;
        if (wa_q.size() !== ea_q.size() || ea_q.size() !== 3) begin
            errors++;
            $display("FAIL good_nwr: got %0d required %0d (3)", wa_q.size(), ea_q.size());
        end
        for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) begin
                errors++;
                $display("FAIL good_wr%0d: got a=%0d d=%0h c=%0d required a=%0d d=%0h c=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k], ea_q[k], ed_q[k], ec_q[k]);
            end
        end
        checks++;
        if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
            errors++;
            $display("FAIL good_status: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                     load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        stim_q = '{8'hA5, 8'h02, 8'hFF, 8'h02, 8'h00};
        send_stim(0);
        run_model();
        checks++;
        if (wa_q.size() !== ea_q.size()) begin
            errors++;
            $display("FAIL badck_nwr: got %0d required %0d", wa_q.size(), ea_q.size());
        end
        for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) begin
                errors++;
                $display("FAIL badck_wr%0d: got a=%0d d=%0h c=%0d required a=%0d d=%0h c=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k], ea_q[k], ed_q[k], ec_q[k]);
            end
        end
        checks++;
        if ({load_done, load_err, cpu_hold} !== {e_done, e_err, e_hold}) begin
            errors++;
            $display("FAIL badck_status: got done=%0b err=%0b hold=%0b required %0b %0b %0b",
                     load_done, load_err, cpu_hold, e_done, e_err, e_hold);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] lens[2];
        lens[0] = 8'h00; lens[1] = 8'h41;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            stim_q = '{8'hA5, lens[t]};
            send_stim(0);
            repeat (3) @(negedge clk);
            run_model();
            checks++;
            if (wa_q.size() !== 0) begin
                errors++;
                $display("FAIL badlen_%0h_nwr: got %0d required 0", lens[t], wa_q.size());
            end
            checks++;
            if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
                errors++;
                $display("FAIL badlen_%0h_status: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                         lens[t], load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
            end
        end
    endtask

    task automatic test_gaps_and_junk();
        do_reset();
        stim_q = '{8'h00, 8'h12, 8'hA5, 8'h01, 8'hA5, 8'hA5};
        send_stim(1);
        run_model();
        checks++;
        if (wa_q.size() !== 1 || ea_q.size() !== 1) begin
            errors++;
            $display("FAIL gaps_nwr: got %0d required %0d (1)", wa_q.size(), ea_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== ea_q[0] || wd_q[0] !== ed_q[0] || wc_q[0] !== ec_q[0]) begin
                errors++;
                $display("FAIL gaps_wr: got a=%0d d=%0h c=%0d required a=%0d d=%0h c=%0d",
                         wa_q[0], wd_q[0], wc_q[0], ea_q[0], ed_q[0], ec_q[0]);
            end
        end
        checks++;
        if ({load_done, load_err, cpu_hold} !== {e_done, e_err, e_hold}) begin
            errors++;
            $display("FAIL gaps_status: got done=%0b err=%0b hold=%0b required %0b %0b %0b",
                     load_done, load_err, cpu_hold, e_done, e_err, e_hold);
        end
    endtask

    task automatic test_full_and_reload();
        int bad;
        do_reset();
        stim_q.push_back(8'hA5); stim_q.push_back(8'h40);
        for (int k = 0; k < NL; k++) stim_q.push_back(8'h01);
        stim_q.push_back(8'h40);
        send_stim(0);
        run_model();
        checks++;
        if (wa_q.size() !== ea_q.size() || ea_q.size() !== NL) begin
            errors++;
            $display("FAIL full_nwr: got %0d required %0d (64)", wa_q.size(), ea_q.size());
        end
        bad = 0;
        for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++)
            if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_wr: got %0d wrong writes required 0", bad);
        end
        checks++;
        if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
            errors++;
            $display("FAIL full_status: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                     load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
        end
        send_byte(8'hA5, 0);
        run_model();
        checks++;
        if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
            errors++;
            $display("FAIL reload_status: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                     load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        stim_q = '{8'hA5, 8'h04, 8'h10, 8'h20};
        send_stim(0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, load_count} !==
            {1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0}) begin
            errors++;
            $display("FAIL midrst_status: got we=%0b a=%0d d=%0h hold=%0b done=%0b err=%0b cnt=%0d required 0 0 0 1 0 0 0",
                     mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, load_count);
        end
        rst_n = 1'b1;
        clear_q();
        stim_q = '{8'h3C, 8'hA5, 8'h02, 8'h07, 8'h08, 8'h0F};
        send_stim(0);
        run_model();
        checks++;
        if (wa_q.size() !== ea_q.size() || ea_q.size() !== 2) begin
            errors++;
            $display("FAIL midrst_nwr: got %0d required %0d (2)", wa_q.size(), ea_q.size());
        end
        for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) begin
                errors++;
                $display("FAIL midrst_wr%0d: got a=%0d d=%0h c=%0d required a=%0d d=%0h c=%0d",
                         k, wa_q[k], wd_q[k], wc_q[k], ea_q[k], ed_q[k], ec_q[k]);
            end
        end
        checks++;
        if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
            errors++;
            $display("FAIL midrst_load: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                     load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
        end
    endtask

    task automatic test_random_frames();
        int L, sum, bad;
        logic [7:0] b;
        do_reset();
        for (int f = 0; f < 24; f++) begin
            clear_q();
            stim_q.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) begin
                L = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(NL + 1, 255));
                stim_q.push_back(8'(L));
            end else begin
                L = int'($urandom_range(1, NL));
                stim_q.push_back(8'(L));
                sum = 0;
                for (int k = 0; k < L; k++) begin
                    b = 8'($urandom_range(0, 255));
                    stim_q.push_back(b);
                    sum = (sum + int'(b)) % 256;
                end
                if ($urandom_range(0, 3) == 0) stim_q.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
                else stim_q.push_back(8'(sum));
            end
            for (int j = int'($urandom_range(0, 2)); j > 0; j--) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                stim_q.push_back(b);
            end
            send_stim(-1);
            run_model();
            bad = 0;
            for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++)
                if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) bad++;
            checks++;
            if (wa_q.size() !== ea_q.size() || bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_wr: got %0d writes (%0d wrong) required %0d writes (0 wrong)",
                         f, wa_q.size(), bad, ea_q.size());
            end
            checks++;
            if ({load_done, load_err, cpu_hold, load_count} !== {e_done, e_err, e_hold, 7'(e_count)}) begin
                errors++;
                $display("FAIL rand%0d_status: got done=%0b err=%0b hold=%0b cnt=%0d required %0b %0b %0b %0d",
                         f, load_done, load_err, cpu_hold, load_count, e_done, e_err, e_hold, e_count);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_gaps_and_junk();
        test_full_and_reload();
        test_reset_midframe();
        test_random_frames();
        checks++;
        if (excl_viol !== 0) begin
            errors++;
            $display("FAIL done_err_exclusive: got %0d overlap cycles required 0", excl_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instmem_loader.md
Name: instmem_loader

Overview:
- Write-side companion to the instruction memory: receives a framed program image as a byte stream from the host link and writes it sequentially into instruction-memory locations 0..N-1 through a write port.
- Holds the core in reset-hold (cpu_hold) until a complete image with a valid checksum has been written.
- Sits between the host byte receiver and the instruction memory write port.

Parameters:
- WORD_WIDTH, 8, instruction word / stream byte width.
- ADDR_WIDTH, 6, instruction memory address width.
- N_LOCATIONS, 64, number of instruction memory locations; maximum legal frame length.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  WORD_WIDTH  host byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per data byte.
- mem_waddr  out  ADDR_WIDTH  write address.
- mem_wdata  out  WORD_WIDTH  write data.
- cpu_hold  out  1  1 = core held; 0 only after a successful load.
- load_done  out  1  last frame loaded with good checksum.
- load_err  out  1  last frame rejected.
- load_count  out  ADDR_WIDTH+1  number of data bytes written in the current/last frame.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, in_ready=0 during reset cycle then 1; mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, load_count=0, checksum accumulator=0. Reset mid-frame abandons the frame; memory contents already written are not touched.
- States: IDLE, LEN, DATA, CHECK, DONE, ERR.
- IDLE: accepted byte == SYNC_BYTE -> LEN, clear load_done/load_err/load_count/accumulator, cpu_hold=1. Any other byte is discarded.
- LEN: accepted byte L. 1 <= L <= N_LOCATIONS -> store L, DATA. L==0 or L>N_LOCATIONS -> ERR.
- DATA: each accepted byte D produces mem_we=1, mem_waddr=load_count[ADDR_WIDTH-1:0], mem_wdata=D in the next cycle (registered, latency 1). Also load_count+=1 and acc=(acc+D) mod 2^WORD_WIDTH. After the L-th byte -> CHECK.
- CHECK: accepted byte C. C==acc -> DONE; otherwise -> ERR. No memory write.
- DONE: load_done=1, cpu_hold=0.
- ERR: load_err=1, cpu_hold=1.
- Reload from DONE/ERR: accepted SYNC_BYTE behaves as in IDLE and re-asserts cpu_hold the cycle after acceptance. Non-sync bytes are discarded.
- in_ready=1 in every state except the reset cycle. Bytes with in_valid=0 are ignored in all states. No state advances without a transfer; arbitrary gaps between bytes are legal.
- mem_we is never asserted outside DATA-accepted bytes; at most one write per cycle; back-to-back bytes give back-to-back writes.
- Sync byte value inside LEN/DATA/CHECK is treated as ordinary data, not a restart.
- Address never wraps: L<=N_LOCATIONS guarantees mem_waddr<=N_LOCATIONS-1.
- Outputs load_done/load_err are mutually exclusive.

Test Plan:
- Reset then stream A5,03,11,22,33,66 back-to-back -> writes (0,11),(1,22),(2,33) on consecutive cycles, each one cycle after acceptance; load_done=1, cpu_hold=0, load_count=3.
- Stream A5,02,FF,02,00 (wrong checksum; correct is 01) -> two writes occur, then load_err=1, cpu_hold=1, load_done=0.
- Stream A5,00 and separately A5,41 (65 > 64) -> ERR immediately after length byte, no mem_we pulses.
- Stream 00,12,A5,01,A5,A5 with in_valid toggling every other cycle -> leading 00,12 ignored; one write (0,A5); load_done=1.
- Full frame A5,40 followed by 64 bytes of 01 and checksum 40 -> addresses 0..63 written, load_count=64, load_done=1. Then send A5 -> cpu_hold returns to 1 next cycle, load_done=0.
- Assert rst_n=0 after the 2nd data byte of a 4-byte frame -> all outputs return to reset values, state IDLE; a subsequent valid frame loads correctly.
